mem_write_checker: RTL

- Synthesizable, parametrised self-checking monitor for the processor's data-memory write port (memwrite/dataadr/writedata).
- Successor to the per-test write check in the processor testbench. It holds a table of up to NUM_EXP expected writes and matches observed writes against it in order.
- Per-entry match mode: full, data-only, or address-only. It bounds each run with a cycle timeout and reports pass/fail, end time and diagnostics.
- Instantiated next to top in benches and in FPGA self-test builds.

---
 rtl/mem_chk_pkg.sv | 21 ++
 rtl/mem_chk_table.sv | 56 +++++
 rtl/mem_write_checker.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mem_chk_pkg.sv
// Shared encodings for the data-memory write checker: match modes, FSM states and fail codes.
package mem_chk_pkg;

    localparam logic [1:0] MODE_FULL = 2'd0;
    localparam logic [1:0] MODE_DATA = 2'd1;
    localparam logic [1:0] MODE_ADDR = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PASS = 2'd2,
        FAIL = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        FAIL_NONE     = 2'd0,
        FAIL_TIMEOUT  = 2'd1,
        FAIL_MISMATCH = 2'd2
    } fail_t;

endpackage

// File: rtl/mem_chk_table.sv
// Expectation table: NUM_EXP entries of {mode, addr, data}, one write port, one read port,
// and a combinational match of the observed write against the selected entry.
module mem_chk_table
    import mem_chk_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NUM_EXP = 4,
    parameter int IW      = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [IW-1:0]    widx,
    input  logic [1:0]       wmode,
    input  logic [WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [IW-1:0]    ridx,
    input  logic [WIDTH-1:0] obs_addr,
    input  logic [WIDTH-1:0] obs_data,
    output logic             hit
);

    logic [1:0]       mode_q [NUM_EXP];
    logic [WIDTH-1:0] addr_q [NUM_EXP];
    logic [WIDTH-1:0] data_q [NUM_EXP];
    logic             a_eq, d_eq;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_EXP; i++) begin
                mode_q[i] <= '0;
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else if (we && (32'(widx) < 32'(NUM_EXP))) begin
            mode_q[widx] <= wmode;
            addr_q[widx] <= waddr;
            data_q[widx] <= wdata;
        end
    end

    assign a_eq = (obs_addr == addr_q[ridx]);
    assign d_eq = (obs_data == data_q[ridx]);

    // Reserved mode 3 falls into the default and compares like full.
    always_comb begin
        hit = a_eq && d_eq;
        case (mode_q[ridx])
            MODE_FULL: hit = a_eq && d_eq;
            MODE_DATA: hit = d_eq;
            MODE_ADDR: hit = a_eq;
            default:   hit = a_eq && d_eq;
        endcase
    end

endmodule

// File: rtl/mem_write_checker.sv
// In-order checker for the data-memory write port with per-run cycle timeout.
// Define MEM_WRITE_CHECKER_STRICT_EN to fail a run on its first mismatching write.
module mem_write_checker
    import mem_chk_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NUM_EXP = 4,
    parameter int TIMEOUT = 1000,
    parameter int CNT_W   = 16,
    localparam int NW     = $clog2(NUM_EXP + 1),
    localparam int IW     = (NUM_EXP > 1) ? $clog2(NUM_EXP) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [NW-1:0]    n_exp,
    input  logic             exp_we,
    input  logic [IW-1:0]    exp_idx,
    input  logic [WIDTH-1:0] exp_addr,
    input  logic [WIDTH-1:0] exp_data,
    input  logic [1:0]       exp_mode,
    input  logic             memwrite,
    input  logic [WIDTH-1:0] dataadr,
    input  logic [WIDTH-1:0] writedata,
    output logic             done,
    output logic             pass,
    output logic [1:0]       fail_code,
    output logic [CNT_W-1:0] end_time,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [WIDTH-1:0] bad_addr,
    output logic [WIDTH-1:0] bad_data
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state, state_next;
    fail_t            fail_next;
    logic [NW-1:0]    n_lat, ptr;
    logic [CNT_W-1:0] cnt, cnt_inc;
    logic             hit, wr_ok, miss, pass_now, tmo;

    mem_chk_table #(.WIDTH(WIDTH), .NUM_EXP(NUM_EXP), .IW(IW)) u_table (
        .clk      (clk),
        .reset    (reset),
        .we       (exp_we && (state != RUN)),
        .widx     (exp_idx),
        .wmode    (exp_mode),
        .waddr    (exp_addr),
        .wdata    (exp_data),
        .ridx     (ptr[IW-1:0]),
        .obs_addr (dataadr),
        .obs_data (writedata),
        .hit      (hit)
    );

    assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
    assign tmo      = 32'(cnt_inc) >= 32'(TIMEOUT);
    assign wr_ok    = (state == RUN) && memwrite && (n_lat != '0);
    assign miss     = wr_ok && !hit;
    assign pass_now = (state == RUN) &&
                      ((n_lat == '0) || (wr_ok && hit && (ptr + NW'(1) == n_lat)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Final match beats timeout; start beats everything, including a same-cycle write.
    always_comb begin
        state_next = state;
        fail_next  = FAIL_NONE;
        if (start) begin
            state_next = RUN;
        end else if (state == RUN) begin
            if (pass_now) begin
                state_next = PASS;
            end
`ifdef MEM_WRITE_CHECKER_STRICT_EN
            else if (miss) begin
                state_next = FAIL;
                fail_next  = FAIL_MISMATCH;
            end
`endif
            else if (tmo) begin
                state_next = FAIL;
                fail_next  = FAIL_TIMEOUT;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            n_lat        <= '0;
            ptr          <= '0;
            cnt          <= '0;
            done         <= 1'b0;
            pass         <= 1'b0;
            fail_code    <= '0;
            end_time     <= '0;
            mismatch_cnt <= '0;
            bad_addr     <= '0;
            bad_data     <= '0;
        end else if (start) begin
            n_lat        <= (32'(n_exp) > 32'(NUM_EXP)) ? NW'(NUM_EXP) : n_exp;
            ptr          <= '0;
            cnt          <= '0;
            done         <= 1'b0;
            pass         <= 1'b0;
            fail_code    <= '0;
            mismatch_cnt <= '0;
            bad_addr     <= '0;
            bad_data     <= '0;
        end else if (state == RUN) begin
            cnt <= cnt_inc;
            if (wr_ok && hit) ptr <= ptr + NW'(1);
            if (miss) begin
                if (mismatch_cnt != CNT_MAX) mismatch_cnt <= mismatch_cnt + CNT_W'(1);
                bad_addr <= dataadr;
                bad_data <= writedata;
            end
            if (state_next != RUN) begin
                done      <= 1'b1;
                pass      <= (state_next == PASS);
                fail_code <= fail_next;
                end_time  <= cnt_inc;
            end
        end
    end

endmodule
